// File: rtl/g_alu32_v2_pkg.sv
// Shared ALU definitions: datapath width, opcode encodings and the word type.
package alu_pkg;

    localparam int ALU_W = 32;

    typedef logic [ALU_W-1:0] word_t;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_NOT   = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_LSL   = 3'd5;
    localparam logic [2:0] OP_LSR   = 3'd6;
    localparam logic [2:0] OP_TRUNC = 3'd7;

endpackage

// File: rtl/g_alu32_v2_if.sv
// Operand/result bundle between the register file side and the ALU.
interface g_alu32_v2_if;
    import alu_pkg::*;

    word_t      In1;
    word_t      In2;
    logic       CI;
    logic [2:0] A;
    word_t      FinalOut;
    logic       CO;

    // Operand source (register file / testbench)
    modport master (
        output In1, In2, CI, A,
        input  FinalOut, CO
    );

    // The ALU itself
    modport slave (
        input  In1, In2, CI, A,
        output FinalOut, CO
    );

endinterface

// File: rtl/g_alu32_v2_barrel_shift32.sv
// Five-stage logarithmic shifter; stage gi shifts by 2**gi when amount[gi] is set.
// One instance serves both shift directions, vacated bits are zero filled.
module g_barrel_shift32
    import alu_pkg::*;
(
    input  word_t      dataIn,
    input  logic [4:0] amount,
    input  logic       shiftLeft,
    output word_t      dataOut
);

    for (genvar gi = 0; gi < 5; gi++) begin : gStage
        localparam int Step = 1 << gi;
        word_t stageIn;
        word_t stageOut;

        if (gi == 0) begin : gFirst
            assign stageIn = dataIn;
        end else begin : gChain
            assign stageIn = gStage[gi-1].stageOut;
        end

        assign stageOut = !amount[gi] ? stageIn :
                          shiftLeft   ? (stageIn << Step) :
                                        (stageIn >> Step);
    end

    assign dataOut = gStage[4].stageOut;

endmodule

// File: rtl/g_alu32_v2.sv
// Registered 32-bit ALU: logic ops, add with carry, shifts and low-half truncate.
// Carry-out always reflects In1+In2+CI, whichever opcode is selected.
module g_alu32_v2
    import alu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    g_alu32_v2_if.slave    bus
);

    word_t sumNext;
    word_t shiftNext;
    word_t resultNext;
    logic  coNext;
    word_t finalOutReg;
    logic  coReg;

    // 33-bit add so the carry falls out as the top bit
    assign {coNext, sumNext} = {1'b0, bus.In1} + {1'b0, bus.In2} + {{ALU_W{1'b0}}, bus.CI};

    // Only In2[4:0] matters as the shift amount, so 0x20 behaves as a shift of 0
    g_barrel_shift32 uShift (
        .dataIn    (bus.In1),
        .amount    (bus.In2[4:0]),
        .shiftLeft (bus.A == OP_LSL),
        .dataOut   (shiftNext)
    );

    // Operation select
    always_comb begin
        resultNext = '0;
        case (bus.A)
            OP_AND:   resultNext = bus.In1 & bus.In2;
            OP_OR:    resultNext = bus.In1 | bus.In2;
            OP_XOR:   resultNext = bus.In1 ^ bus.In2;
            OP_NOT:   resultNext = ~bus.In1;
            OP_ADD:   resultNext = sumNext;
            OP_LSL:   resultNext = shiftNext;
            OP_LSR:   resultNext = shiftNext;
            OP_TRUNC: resultNext = {16'h0000, bus.In1[15:0]};
            default:  resultNext = '0;
        endcase
    end

    // Output register, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finalOutReg <= '0;
            coReg       <= 1'b0;
        end else begin
            finalOutReg <= resultNext;
            coReg       <= coNext;
        end
    end

    assign bus.FinalOut = finalOutReg;
    assign bus.CO       = coReg;

endmodule

// File: tb/tb_g_alu32_v2.sv
// Scoreboard bench for g_alu32_v2: stimulus pushes expectations, a monitor
// pops and compares one cycle after each operation is applied.
module tb_g_alu32_v2;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic [2:0]  op;
        int          idx;
    } exp_t;

    logic clk;
    logic rst_n;
    g_alu32_v2_if bus ();

    g_alu32_v2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t expQ[$];
    int   numChecks = 0;
    int   numErrors = 0;
    int   vecIdx    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, written independently of the RTL structure
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic ci, input logic [2:0] op,
                                  output logic [31:0] res, output logic co);
        logic [63:0] wide;
        logic [63:0] pow2;
        wide = 64'(a) + 64'(b) + 64'(ci);
        co   = wide[32];
        pow2 = 64'd1 << b[4:0];
        case (op)
            3'd0: res = a & b;
            3'd1: res = a | b;
            3'd2: res = a ^ b;
            3'd3: res = ~a;
            3'd4: res = wide[31:0];
            3'd5: res = 32'((64'(a) * pow2) & 64'hFFFF_FFFF);
            3'd6: res = 32'(64'(a) / pow2);
            default: res = a & 32'h0000_FFFF;
        endcase
    endfunction

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input logic [2:0] op, input logic [31:0] res, input logic co);
        exp_t e;
        @(negedge clk);
        bus.In1 = a;
        bus.In2 = b;
        bus.CI  = ci;
        bus.A   = op;
        e.res = res;
        e.co  = co;
        e.op  = op;
        e.idx = vecIdx;
        vecIdx++;
        expQ.push_back(e);
    endtask

    task automatic applyModel(input logic [31:0] a, input logic [31:0] b,
                              input logic ci, input logic [2:0] op);
        logic [31:0] r;
        logic        c;
        model(a, b, ci, op, r, c);
        apply(a, b, ci, op, r, c);
    endtask

    task automatic checkZero(input string name);
        numChecks++;
        if (bus.FinalOut !== 32'h0 || bus.CO !== 1'b0) begin
            numErrors++;
            $display("FAIL %s: got FinalOut=%08h CO=%b, want FinalOut=00000000 CO=0",
                     name, bus.FinalOut, bus.CO);
        end else
            $display("ok   %s: FinalOut=%08h CO=%b", name, bus.FinalOut, bus.CO);
    endtask

    // Monitor: each edge with an outstanding expectation produces one result
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            numChecks++;
            if (bus.FinalOut !== e.res || bus.CO !== e.co) begin
                numErrors++;
                $display("FAIL vec%0d op%0d: got FinalOut=%08h CO=%b, want FinalOut=%08h CO=%b",
                         e.idx, e.op, bus.FinalOut, bus.CO, e.res, e.co);
            end else if (e.idx < 40)
                $display("ok   vec%0d op%0d: FinalOut=%08h CO=%b",
                         e.idx, e.op, bus.FinalOut, bus.CO);
        end
    end

    localparam logic [31:0] SweepRes [0:7] = '{
        32'h0F0F_0000, 32'hFFFF_0F0F, 32'hF0F0_0F0F, 32'h0000_FFFF,
        32'h0F0E_0F10, 32'h8000_0000, 32'h0001_FFFE, 32'h0000_0000
    };

    initial begin
        logic [31:0] r1, r2;
        logic        c1;

        // Reset with arbitrary inputs, checked before any clock edge
        rst_n   = 1'b0;
        bus.In1 = 32'hDEAD_BEEF;
        bus.In2 = 32'hFFFF_FFFF;
        bus.CI  = 1'b1;
        bus.A   = OP_ADD;
        #1;
        checkZero("reset_before_edge");
        repeat (2) @(posedge clk);
        #1;
        checkZero("reset_held_over_edges");
        @(negedge clk);
        rst_n = 1'b1;

        // Opcode sweep with hand-computed results; carry is 1 throughout
        for (int op = 0; op < 8; op++)
            apply(32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 3'(op), SweepRes[op], 1'b1);

        // Add wrap
        apply(32'hFFFF_FFFF, 32'h0, 1'b1, OP_ADD, 32'h0000_0000, 1'b1);
        apply(32'hFFFF_FFFF, 32'h0, 1'b0, OP_ADD, 32'hFFFF_FFFF, 1'b0);

        // Shift boundaries
        apply(32'h8000_0001, 32'h20, 1'b0, OP_LSL, 32'h8000_0001, 1'b0);
        apply(32'h8000_0001, 32'h20, 1'b0, OP_LSR, 32'h8000_0001, 1'b0);
        apply(32'h8000_0001, 32'd31, 1'b0, OP_LSL, 32'h8000_0000, 1'b0);
        apply(32'h8000_0001, 32'd31, 1'b0, OP_LSR, 32'h0000_0001, 1'b0);

        // Truncate; carry still tracks the adder
        apply(32'h1234_5678, 32'h0, 1'b0, OP_TRUNC, 32'h0000_5678, 1'b0);
        apply(32'h1234_5678, 32'hF000_0000, 1'b0, OP_TRUNC, 32'h0000_5678, 1'b1);

        // Reset mid-stream while running ADD
        apply(32'h0000_0001, 32'h0000_0002, 1'b1, OP_ADD, 32'h0000_0004, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkZero("reset_midstream");
        @(posedge clk);
        #1;
        checkZero("reset_midstream_held");
        @(negedge clk);
        rst_n = 1'b1;
        bus.In1 = 32'h8000_0000;
        bus.In2 = 32'h8000_0000;
        bus.CI  = 1'b1;
        bus.A   = OP_ADD;
        begin
            exp_t e;
            e.res = 32'h0000_0001;
            e.co  = 1'b1;
            e.op  = OP_ADD;
            e.idx = vecIdx;
            vecIdx++;
            expQ.push_back(e);
        end

        // Random vectors against the model
        for (int i = 0; i < 1000; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            c1 = 1'($urandom_range(0, 1));
            for (int op = 0; op < 8; op++)
                applyModel(r1, r2, c1, 3'(op));
        end

        repeat (2) @(negedge clk);
        numChecks++;
        if (expQ.size() != 0) begin
            numErrors++;
            $display("FAIL drain: got %0d results outstanding, want 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
        $finish;
    end

endmodule
